mem_burst_responder: RTL and testbench

- Multi-cycle main-memory responder: the memory-side end of the CPU/cache memory request interface.
- Accepts single-word writes and block-fill reads from an initiator (cache-fill FSM or pipeline MEM stage).
- Reads are returned as a BURST_LEN-word burst over a fixed-latency pipelined path.
- Replaces the single-cycle data memory once caches are added.

---
 rtl/mem_burst_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_burst_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_responder.sv
// Memory-side responder: single-word writes complete in one cycle, reads return a
// block-aligned burst of BURST_LEN words through a fixed LATENCY-deep pipeline.
module mem_burst_responder #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy
);

    localparam int WORDS = 2 ** (ADDR_W - 1);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_K   = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              iss_valid;
    logic              iss_last;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_data;
    logic              mem_we;

    logic [DATA_W-1:0] mem [WORDS];

    // Stage LATENCY-1 is the registered output stage.
    logic              stg_valid_q [LATENCY];
    logic              stg_valid_d [LATENCY];
    logic              stg_last_q  [LATENCY];
    logic              stg_last_d  [LATENCY];
    logic [ADDR_W-1:0] stg_addr_q  [LATENCY];
    logic [ADDR_W-1:0] stg_addr_d  [LATENCY];
    logic [DATA_W-1:0] stg_data_q  [LATENCY];
    logic [DATA_W-1:0] stg_data_d  [LATENCY];

    logic              chain_valid [LATENCY];
    logic              chain_last  [LATENCY];
    logic [ADDR_W-1:0] chain_addr  [LATENCY];
    logic [DATA_W-1:0] chain_data  [LATENCY];

    // valid/ready: a request transfers on a rising edge with req_valid & req_ready;
    // the response side has no ready and is never stalled.
    assign req_ready = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);

    assign rsp_valid = stg_valid_q[LATENCY-1];
    assign rsp_last  = stg_last_q[LATENCY-1];
    assign rsp_addr  = stg_addr_q[LATENCY-1];
    assign rsp_data  = stg_data_q[LATENCY-1];

    assign iss_data = mem[iss_addr[ADDR_W-1:1]];

    // cnt_q holds the index of the next word to issue; word 0 goes out at the handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        mem_we    = 1'b0;
        iss_valid = 1'b0;
        iss_addr  = base_q | ADDR_W'({cnt_q, 1'b0});
        iss_last  = (cnt_q == LAST_K);
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_write) begin
                        mem_we = 1'b1;
                    end else begin
                        iss_valid = 1'b1;
                        iss_addr  = req_addr & BLK_MASK;
                        iss_last  = (BURST_LEN == 1);
                        base_d    = req_addr & BLK_MASK;
                        if (BURST_LEN == 1) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            state_d = ISSUE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                iss_valid = 1'b1;
                if (cnt_q == LAST_K) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (rsp_valid && rsp_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage keeps addr/data when no new word arrives.
    always_comb begin
        chain_valid[0] = iss_valid;
        chain_last[0]  = iss_last;
        chain_addr[0]  = iss_addr;
        chain_data[0]  = iss_data;
        for (int i = 1; i < LATENCY; i++) begin
            chain_valid[i] = stg_valid_q[i-1];
            chain_last[i]  = stg_last_q[i-1];
            chain_addr[i]  = stg_addr_q[i-1];
            chain_data[i]  = stg_data_q[i-1];
        end
        for (int i = 0; i < LATENCY; i++) begin
            stg_valid_d[i] = chain_valid[i];
            stg_last_d[i]  = chain_valid[i] & chain_last[i];
            stg_addr_d[i]  = chain_addr[i];
            stg_data_d[i]  = chain_data[i];
            if ((i == LATENCY - 1) && !chain_valid[i]) begin
                stg_addr_d[i] = stg_addr_q[i];
                stg_data_d[i] = stg_data_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_valid_q[i] <= 1'b0;
                stg_last_q[i]  <= 1'b0;
                stg_addr_q[i]  <= '0;
                stg_data_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            for (int i = 0; i < LATENCY; i++) begin
                stg_valid_q[i] <= stg_valid_d[i];
                stg_last_q[i]  <= stg_last_d[i];
                stg_addr_q[i]  <= stg_addr_d[i];
                stg_data_q[i]  <= stg_data_d[i];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_addr[ADDR_W-1:1]] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: directed scenarios plus random traffic, checked by a
// cycle-accurate expected-response queue built from a simple memory model.
module tb_mem_burst_responder;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int BL  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_last;
    logic          busy;

    mem_burst_responder #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_last(rsp_last), .busy(busy)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic          known;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];
    int            tests  = 0;
    int            fails  = 0;
    int            blk_lo = -1;
    int            blk_hi = -1;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected burst: block-aligned base, word k due LAT+k cycles after the handshake.
    task automatic model_read(input logic [AW-1:0] a, input int hs);
        logic [AW-1:0] base;
        exp_t          e;
        base = a & ~16'(2 * BL - 1);
        for (int k = 0; k < BL; k++) begin
            e.cyc   = 32'(hs + LAT + k);
            e.addr  = base + 16'(2 * k);
            e.known = ref_mem.exists(int'(e.addr[AW-1:1]));
            e.data  = e.known ? ref_mem[int'(e.addr[AW-1:1])] : '0;
            e.last  = (k == BL - 1);
            exp_q.push_back(e);
        end
        blk_lo = hs;
        blk_hi = hs + LAT + BL - 1;
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the edge that took the request.
    task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int hs);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        hs = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                hs = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (hs < 0) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: addr 0x%0h never accepted within 200 cycles", a);
            req_valid = 1'b0;
            return;
        end
        if (wr) ref_mem[int'(a[AW-1:1])] = d;
        else    model_read(a, hs);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic post_reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_ready"},     req_ready, 1);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_last"},  rsp_last,  0);
        check({tag, "_rsp_data"},  rsp_data,  0);
        check({tag, "_rsp_addr"},  rsp_addr,  0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    exp_t e_mon;
    logic exp_rdy;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                check("ready_in_rst", req_ready, 0);
            end else begin
                exp_rdy = !(cyc > blk_lo && cyc <= blk_hi);
                check("req_ready", req_ready, exp_rdy);
                check("busy", busy, !exp_rdy);
                while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_word: addr 0x%0h due cycle %0d, absent at cycle %0d",
                             exp_q[0].addr, exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
                if (rsp_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                                 rsp_addr, rsp_data, cyc);
                    end else begin
                        e_mon = exp_q.pop_front();
                        check("rsp_cycle", cyc, e_mon.cyc);
                        check("rsp_addr", rsp_addr, e_mon.addr);
                        check("rsp_last", rsp_last, e_mon.last);
                        if (e_mon.known) check("rsp_data", rsp_data, e_mon.data);
                    end
                end else begin
                    check("rsp_valid", rsp_valid, 0);
                    check("rsp_last_idle", rsp_last, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int hs, hs0, hs_r, hs_w, hs2;
    logic [AW-1:0] ra;
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // 1. reset
        repeat (2) begin
            @(negedge clk);
            check("ready_during_rst", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        post_reset_checks("init");
        mon_en = 1'b1;

        // 2. back-to-back writes, then block read from the middle of the block
        for (int k = 0; k < BL; k++) begin
            send(1'b1, 16'h0010 + 16'(2 * k), 16'hA000 + 16'(k), hs);
            if (k == 0) hs0 = hs;
            else        check("write_b2b_cycle", hs, hs0 + k);
        end
        send(1'b0, 16'h0016, '0, hs_r);
        idle(LAT + BL + 2);

        // 3. write held during a burst is accepted the cycle ready returns
        for (int k = 0; k < BL; k++) send(1'b1, 16'h0040 + 16'(2 * k), 16'h5500 + 16'(k), hs);
        send(1'b0, 16'h0044, '0, hs_r);
        send(1'b1, 16'h0040, 16'h1234, hs_w);
        check("held_write_accept", hs_w, hs_r + LAT + BL);
        send(1'b0, 16'h0040, '0, hs);
        idle(LAT + BL + 2);

        // 4. reset in cycle 6 of a burst, then re-read
        send(1'b0, 16'h0010, '0, hs_r);
        idle(5);
        check("abort_cycle", cyc, hs_r + 6);
        rst = 1'b1;
        exp_q.delete();
        blk_lo = -1;
        blk_hi = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        post_reset_checks("abort");
        send(1'b0, 16'h001C, '0, hs);
        idle(LAT + BL + 2);

        // 5. top block of the address space
        for (int k = 0; k < BL; k++) send(1'b1, 16'hFFF0 + 16'(2 * k), 16'(16'h7700 + k * 3), hs);
        send(1'b0, 16'hFFF2, '0, hs);
        idle(LAT + BL + 2);

        // 6. back-to-back reads
        send(1'b0, 16'h0010, '0, hs_r);
        send(1'b0, 16'hFFFF, '0, hs2);
        check("b2b_read_accept", hs2, hs_r + LAT + BL);
        idle(LAT + BL + 2);

        // random traffic over a preloaded pool of blocks
        for (int w = 0; w < 128; w++) send(1'b1, 16'h2000 + 16'(2 * w), 16'($urandom), hs);
        for (int n = 0; n < 40; n++) begin
            ra = 16'h2000 + 16'(2 * $urandom_range(0, 127)) + 16'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) send(1'b0, ra, '0, hs);
            else                           send(1'b1, ra, 16'($urandom), hs);
            idle($urandom_range(0, 2));
        end

        // drain
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk);
        idle(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected words outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
